// File: rtl/adc_param_smoother.sv
// Exponential smoother for three ADC words delivered by an SPI receiver.
// A synchronised frame flag latches the words, one shared filter datapath
// updates each accumulator in turn, and the results are published together.
module adc_param_smoother #(
   parameter int unsigned SHIFT   = 3,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_data_received,
   input  logic [15:0] i_data0,
   input  logic [15:0] i_data1,
   input  logic [15:0] i_data2,
   output logic [15:0] o_param0,
   output logic [15:0] o_param1,
   output logic [15:0] o_param2,
   output logic        o_update,
   output logic        o_stale,
   output logic        o_overrun,
   output logic [7:0]  o_frame_count
);

   typedef enum logic [2:0] {
      StIdle,
      StFilt0,
      StFilt1,
      StFilt2,
      StDone
   } state_t;

   state_t state_q, state_d;

   logic        sync1_q, sync2_q, hist_q;
   logic        frame_event;
   logic        pending_q, primed_q;
   logic [15:0] shadow_q [3];
   logic [15:0] acc_q [3];
   logic [15:0] wd_q, wd_d;

   // FSM control strobes
   logic        latch_shadow;
   logic        set_pending;
   logic        clr_pending;
   logic        set_overrun;
   logic        filt_en;
   logic [1:0]  filt_idx;
   logic        done;

   // Filter datapath
   logic [15:0]        sel_shadow, sel_acc;
   logic signed [16:0] diff, shifted, step;
   logic signed [17:0] sum;
   logic [15:0]        clamped, new_acc;

   // Rising edge of the synchronised flag marks a new frame
   assign frame_event = sync2_q & ~hist_q;

   // Two-flop synchroniser plus history flop for the asynchronous frame flag
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= i_data_received;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_d      = state_q;
      latch_shadow = 1'b0;
      set_pending  = 1'b0;
      clr_pending  = 1'b0;
      set_overrun  = 1'b0;
      filt_en      = 1'b0;
      filt_idx     = 2'd0;
      done         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_event) begin
               latch_shadow = 1'b1;
               state_d      = StFilt0;
            end
         end
         StFilt0: begin
            filt_en  = 1'b1;
            filt_idx = 2'd0;
            state_d  = StFilt1;
         end
         StFilt1: begin
            filt_en  = 1'b1;
            filt_idx = 2'd1;
            state_d  = StFilt2;
         end
         StFilt2: begin
            filt_en  = 1'b1;
            filt_idx = 2'd2;
            state_d  = StDone;
         end
         StDone: begin
            done = 1'b1;
            if (pending_q || frame_event) begin
               // Chain straight into the queued frame; a further event now is lost
               latch_shadow = 1'b1;
               clr_pending  = 1'b1;
               set_overrun  = pending_q & frame_event;
               state_d      = StFilt0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (frame_event && (state_q == StFilt0 || state_q == StFilt1 || state_q == StFilt2)) begin
         if (pending_q) begin
            set_overrun = 1'b1;
         end else begin
            set_pending = 1'b1;
         end
      end
   end

   // Shared filter arithmetic for the channel selected by the FSM
   always_comb begin
      sel_shadow = shadow_q[0];
      sel_acc    = acc_q[0];
      unique case (filt_idx)
         2'd1: begin
            sel_shadow = shadow_q[1];
            sel_acc    = acc_q[1];
         end
         2'd2: begin
            sel_shadow = shadow_q[2];
            sel_acc    = acc_q[2];
         end
         default: begin
            sel_shadow = shadow_q[0];
            sel_acc    = acc_q[0];
         end
      endcase
      diff    = $signed({1'b0, sel_shadow}) - $signed({1'b0, sel_acc});
      shifted = diff >>> SHIFT;
      step    = shifted;
      // Never stall short of the target: move at least one LSB
      if (shifted == 17'sd0 && diff != 17'sd0) begin
         step = diff[16] ? -17'sd1 : 17'sd1;
      end
      sum = $signed({2'b00, sel_acc}) + $signed({step[16], step});
      if (sum[17]) begin
         clamped = 16'h0000;
      end else if (sum[16]) begin
         clamped = 16'hFFFF;
      end else begin
         clamped = sum[15:0];
      end
      new_acc = (!primed_q || SHIFT == 0) ? sel_shadow : clamped;
   end

   // Shadows, accumulators, published parameters and status
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int n = 0; n < 3; n++) begin
            shadow_q[n] <= 16'h0000;
            acc_q[n]    <= 16'h0000;
         end
         o_param0      <= 16'h0000;
         o_param1      <= 16'h0000;
         o_param2      <= 16'h0000;
         o_update      <= 1'b0;
         o_overrun     <= 1'b0;
         o_frame_count <= 8'd0;
         pending_q     <= 1'b0;
         primed_q      <= 1'b0;
      end else begin
         o_update <= done;
         if (latch_shadow) begin
            shadow_q[0] <= i_data0;
            shadow_q[1] <= i_data1;
            shadow_q[2] <= i_data2;
         end
         for (int n = 0; n < 3; n++) begin
            if (filt_en && filt_idx == 2'(n)) begin
               acc_q[n] <= new_acc;
            end
         end
         if (done) begin
            o_param0      <= acc_q[0];
            o_param1      <= acc_q[1];
            o_param2      <= acc_q[2];
            o_frame_count <= o_frame_count + 8'd1;
            primed_q      <= 1'b1;
         end
         if (set_pending) begin
            pending_q <= 1'b1;
         end else if (clr_pending) begin
            pending_q <= 1'b0;
         end
         if (set_overrun) begin
            o_overrun <= 1'b1;
         end
      end
   end

   // Watchdog next value: a frame event always wins over saturation
   always_comb begin
      if (frame_event) begin
         wd_d = 16'd0;
      end else if (wd_q == TIMEOUT) begin
         wd_d = wd_q;
      end else begin
         wd_d = wd_q + 16'd1;
      end
   end

   // Watchdog counter and registered stale flag
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wd_q    <= 16'd0;
         o_stale <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         o_stale <= (wd_d == TIMEOUT);
      end
   end

endmodule

// File: tb/tb_adc_param_smoother.sv
// Self-checking bench for adc_param_smoother: scoreboard of expected
// parameter sets plus per-scenario directed checks.
module tb_adc_param_smoother;

   localparam int unsigned SHIFT   = 3;
   localparam logic [15:0] TIMEOUT = 16'd100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b0;
   logic [15:0] d0 = '0, d1 = '0, d2 = '0;
   logic [15:0] p0, p1, p2;
   logic        update, stale, overrun;
   logic [7:0]  fcount;

   adc_param_smoother #(
      .SHIFT   (SHIFT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_data_received (rx),
      .i_data0         (d0),
      .i_data1         (d1),
      .i_data2         (d2),
      .o_param0        (p0),
      .o_param1        (p1),
      .o_param2        (p2),
      .o_update        (update),
      .o_stale         (stale),
      .o_overrun       (overrun),
      .o_frame_count   (fcount)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] e0, e1, e2;
      logic [7:0]  fc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          n_updates = 0;
   logic [15:0] m_acc [3];
   logic        m_primed = 1'b0;
   logic [7:0]  m_fc = 8'd0;

   function automatic logic [15:0] model_filt(input logic [15:0] acc, input logic [15:0] x,
                                              input logic primed);
      int diff, step, res;
      if (!primed) return x;
      diff = int'({16'd0, x}) - int'({16'd0, acc});
      step = diff >>> SHIFT;
      if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
      res = int'({16'd0, acc}) + step;
      if (res < 0) res = 0;
      if (res > 65535) res = 65535;
      return res[15:0];
   endfunction

   task automatic model_push(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
      exp_t e;
      m_acc[0] = model_filt(m_acc[0], x0, m_primed);
      m_acc[1] = model_filt(m_acc[1], x1, m_primed);
      m_acc[2] = model_filt(m_acc[2], x2, m_primed);
      m_primed = 1'b1;
      m_fc     = m_fc + 8'd1;
      e.e0 = m_acc[0];
      e.e1 = m_acc[1];
      e.e2 = m_acc[2];
      e.fc = m_fc;
      sb.push_back(e);
   endtask

   task automatic model_clear();
      sb.delete();
      for (int n = 0; n < 3; n++) m_acc[n] = 16'h0000;
      m_primed = 1'b0;
      m_fc     = 8'd0;
   endtask

   // Called at a falling edge; leaves reset released at a falling edge
   task automatic do_reset();
      reset = 1'b1;
      rx    = 1'b0;
      repeat (2) @(negedge clock);
      model_clear();
      reset = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
      d0 = x0;
      d1 = x1;
      d2 = x2;
      rx = 1'b1;
      model_push(x0, x1, x2);
      repeat (3) @(negedge clock);
      rx = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   // Scoreboard consumer and parameter-hold monitor
   initial begin
      exp_t        e;
      logic [15:0] q0 = '0, q1 = '0, q2 = '0;
      logic        rst_prev = 1'b1;
      forever begin
         @(negedge clock);
         if (update) begin
            n_updates++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_update: got params %h %h %h count %0d, required no update",
                        p0, p1, p2, fcount);
            end else begin
               e = sb.pop_front();
               if ({p0, p1, p2, fcount} !== {e.e0, e.e1, e.e2, e.fc}) begin
                  bad++;
                  $display("FAIL update_params: got %h %h %h count %0d, required %h %h %h count %0d",
                           p0, p1, p2, fcount, e.e0, e.e1, e.e2, e.fc);
               end
            end
         end else if (!reset && !rst_prev) begin
            total++;
            if ({p0, p1, p2} !== {q0, q1, q2}) begin
               bad++;
               $display("FAIL param_hold: got %h %h %h, required %h %h %h", p0, p1, p2, q0, q1, q2);
            end
         end
         q0 = p0;
         q1 = p1;
         q2 = p2;
         rst_prev = reset;
      end
   end

   task automatic test_reset();
      do_reset();
      @(negedge clock);
      total++;
      if ({p0, p1, p2, update, stale, overrun, fcount} !== 59'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h %h %h upd %b stale %b ovr %b cnt %0d, required all 0",
                  p0, p1, p2, update, stale, overrun, fcount);
      end
   endtask

   task automatic test_first_frame();
      int lat = 0;
      int u0 = n_updates;
      do_reset();
      d0 = 16'h1000;
      d1 = 16'h2000;
      d2 = 16'hFFFF;
      rx = 1'b1;
      model_push(d0, d1, d2);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         if (i == 3) rx = 1'b0;
         if (update && lat == 0) lat = i;
      end
      total++;
      if (lat != 7) begin
         bad++;
         $display("FAIL update_latency: got %0d, required 7", lat);
      end
      total++;
      if ({p0, p1, p2, fcount} !== {16'h1000, 16'h2000, 16'hFFFF, 8'd1}) begin
         bad++;
         $display("FAIL first_frame: got %h %h %h cnt %0d, required 1000 2000 ffff cnt 1",
                  p0, p1, p2, fcount);
      end
      total++;
      if (n_updates - u0 != 1) begin
         bad++;
         $display("FAIL first_frame_pulses: got %0d, required 1", n_updates - u0);
      end
   endtask

   task automatic test_filter();
      do_reset();
      send_frame(16'h1000, 16'h0000, 16'h0000);
      send_frame(16'h1800, 16'h0000, 16'h0000);
      total++;
      if (p0 !== 16'h1100) begin
         bad++;
         $display("FAIL filter_step: got %h, required 1100", p0);
      end
      do_reset();
      send_frame(16'h1000, 16'h0000, 16'h0000);
      send_frame(16'h1003, 16'h0000, 16'h0000);
      total++;
      if (p0 !== 16'h1001) begin
         bad++;
         $display("FAIL filter_min_up: got %h, required 1001", p0);
      end
      do_reset();
      send_frame(16'h0008, 16'h0000, 16'h0000);
      send_frame(16'h0000, 16'h0000, 16'h0000);
      total++;
      if (p0 !== 16'h0007) begin
         bad++;
         $display("FAIL filter_min_down: got %h, required 0007", p0);
      end
      for (int i = 0; i < 100; i++) send_frame(16'h1800, 16'h2000, 16'h0000);
      total++;
      if ({p0, p1, p2} !== {16'h1800, 16'h2000, 16'h0000}) begin
         bad++;
         $display("FAIL filter_converge: got %h %h %h, required 1800 2000 0000", p0, p1, p2);
      end
   endtask

   // Frame A event lands in IDLE, frame B event during FILT1; optionally a
   // third event while B is still pending
   task automatic run_burst(input logic third);
      d0 = 16'h0111;
      d1 = 16'h0222;
      d2 = 16'h0333;
      rx = 1'b1;
      model_push(d0, d1, d2);
      @(negedge clock);
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      @(negedge clock);
      d0 = 16'h0999;
      d1 = 16'h0888;
      d2 = 16'h0777;
      rx = 1'b0;
      model_push(d0, d1, d2);
      @(negedge clock);
      rx = third;
      @(negedge clock);
      rx = 1'b0;
      repeat (14) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      int u0;
      do_reset();
      u0 = n_updates;
      run_burst(1'b0);
      total++;
      if (n_updates - u0 != 2 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL back_to_back: got %0d updates ovr %b, required 2 updates ovr 0",
                  n_updates - u0, overrun);
      end
   endtask

   task automatic test_overrun();
      int u0;
      do_reset();
      u0 = n_updates;
      run_burst(1'b1);
      total++;
      if (n_updates - u0 != 2 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun: got %0d updates ovr %b, required 2 updates ovr 1",
                  n_updates - u0, overrun);
      end
      send_frame(16'h0444, 16'h0555, 16'h0666);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky: got %b, required 1", overrun);
      end
      do_reset();
      @(negedge clock);
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_clear: got %b, required 0", overrun);
      end
   endtask

   task automatic test_stale();
      do_reset();
      repeat (95) @(negedge clock);
      total++;
      if (stale !== 1'b0) begin
         bad++;
         $display("FAIL stale_early: got %b, required 0", stale);
      end
      repeat (10) @(negedge clock);
      total++;
      if (stale !== 1'b1) begin
         bad++;
         $display("FAIL stale_set: got %b, required 1", stale);
      end
      send_frame(16'h0100, 16'h0200, 16'h0300);
      total++;
      if (stale !== 1'b0) begin
         bad++;
         $display("FAIL stale_clear: got %b, required 0", stale);
      end
      repeat (80) @(negedge clock);
      total++;
      if (stale !== 1'b0) begin
         bad++;
         $display("FAIL stale_restart_early: got %b, required 0", stale);
      end
      repeat (20) @(negedge clock);
      total++;
      if (stale !== 1'b1) begin
         bad++;
         $display("FAIL stale_restart_set: got %b, required 1", stale);
      end
   endtask

   task automatic test_reset_mid();
      int u0;
      do_reset();
      send_frame(16'h4000, 16'h5000, 16'h6000);
      u0 = n_updates;
      d0 = 16'h1234;
      d1 = 16'h2345;
      d2 = 16'h3456;
      rx = 1'b1;
      repeat (3) @(negedge clock);
      rx = 1'b0;
      repeat (2) @(negedge clock);
      do_reset();
      repeat (10) @(negedge clock);
      total++;
      if (n_updates != u0 || {p0, p1, p2, update, stale, overrun, fcount} !== 59'd0) begin
         bad++;
         $display("FAIL reset_mid: got %0d updates params %h %h %h cnt %0d, required 0 updates all 0",
                  n_updates - u0, p0, p1, p2, fcount);
      end
      send_frame(16'h0ABC, 16'h0000, 16'h0000);
      total++;
      if (p0 !== 16'h0ABC) begin
         bad++;
         $display("FAIL reset_mid_reprime: got %h, required 0abc", p0);
      end
   endtask

   task automatic test_rx_at_reset();
      int u0 = n_updates;
      reset = 1'b1;
      d0 = 16'h7777;
      d1 = 16'h8888;
      d2 = 16'h9999;
      rx = 1'b1;
      repeat (2) @(negedge clock);
      model_clear();
      model_push(d0, d1, d2);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b0;
      repeat (10) @(negedge clock);
      total++;
      if (n_updates - u0 != 1 || p0 !== 16'h7777) begin
         bad++;
         $display("FAIL rx_at_reset: got %0d updates p0 %h, required 1 update p0 7777",
                  n_updates - u0, p0);
      end
   endtask

   task automatic test_wrap();
      int u0;
      do_reset();
      u0 = n_updates;
      for (int i = 0; i < 256; i++) begin
         send_frame(16'(i * 257), 16'(65535 - i * 3), 16'(i * 13));
      end
      total++;
      if (fcount !== 8'd0 || n_updates - u0 != 256) begin
         bad++;
         $display("FAIL frame_wrap: got cnt %0d updates %0d, required cnt 0 updates 256",
                  fcount, n_updates - u0);
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_first_frame();
      test_filter();
      test_back_to_back();
      test_overrun();
      test_stale();
      test_reset_mid();
      test_rx_at_reset();
      test_wrap();
      repeat (4) @(negedge clock);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL missing_updates: got %0d outstanding, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_param_smoother.md
ADC_PARAM_SMOOTHER -- requirements
Module: adc_param_smoother

Interface
REQ-001 The block SHALL use reset i_reset, synchronous, active-high; clock i_clock.
REQ-002 Parameter: SHIFT, default 3, smoothing coefficient 1/2^SHIFT (legal 0..8).
REQ-003 Parameter: TIMEOUT, default 16'd50000, i_clock cycles without a frame before o_stale asserts.
REQ-004 Port: i_clock  in  1  system clock.
REQ-005 Port: i_reset  in  1  synchronous active-high reset.
REQ-006 Port: i_data_received  in  1  frame-complete flag from SPI receiver, asynchronous to i_clock; level, not pulse.
REQ-007 Port: i_data0 / i_data1 / i_data2  in  16 each  unsigned received words; stable while i_data_received is high.
REQ-008 Port: o_param0 / o_param1 / o_param2  out  16 each  smoothed unsigned parameters.
REQ-009 Port: o_update  out  1  one-cycle strobe, new o_param values valid.
REQ-010 Port: o_stale  out  1  high when no frame seen for TIMEOUT cycles.
REQ-011 Port: o_overrun  out  1  sticky: a frame was dropped.
REQ-012 Port: o_frame_count  out  8  frames processed, wraps 255->0.

Function
REQ-013 i_data_received SHALL pass a 2-flop synchroniser plus one history flop; event D = synced high and history low (rising edge only).
REQ-014 FSM states SHALL be IDLE, FILT0, FILT1, FILT2, DONE; one cycle each outside IDLE.
REQ-015 IDLE with event in cycle D: latch i_data0..2 into shadow regs at end of D, go FILT0 (cycle D+1).
REQ-016 FILTn: diff = shadow_n - acc_n as 17-bit signed; step = diff >>> SHIFT (arithmetic); if step==0 and diff!=0, step = sign(diff) (+1/-1); acc_n <= acc_n + step, clamped to 0..65535.
REQ-017 First frame after reset (primed==0): FILTn loads acc_n <= shadow_n directly; primed set in DONE.
REQ-018 SHIFT==0: acc_n <= shadow_n every frame.
REQ-019 DONE: o_param0..2 <= acc0..2 simultaneously; o_update high during cycle D+5 only, the first cycle new o_param values are visible; o_frame_count increments.
REQ-020 Event while not in IDLE: set pending flag; DONE with pending latches shadows immediately and goes FILT0 (no IDLE cycle), clears pending.
REQ-021 Event while pending already set: frame dropped, o_overrun <= 1, held until reset.
REQ-022 Watchdog counter: increments each cycle, saturates at TIMEOUT, cleared to 0 on every event; o_stale = (counter == TIMEOUT), registered.
REQ-023 o_param outputs SHALL not change outside DONE cycles.
REQ-024 Event in same cycle as watchdog reaching TIMEOUT: clear wins, o_stale stays 0.

Reset
REQ-025 On i_reset: o_param0..2=0, acc=0, shadows=0, o_update=0, o_stale=0, o_overrun=0, o_frame_count=0, counter=0, pending=0, primed=0, synchroniser flops=0, state IDLE.
REQ-026 Reset mid-FSM SHALL abort the frame with no o_update; next event treated as first frame (REQ-017).
REQ-027 i_data_received high when reset releases: synchroniser rises from 0, counted as one event.

Verification
REQ-028 Reset, frame 0x1000/0x2000/0xFFFF -> o_param=0x1000/0x2000/0xFFFF exactly, one o_update pulse 5 cycles after event, o_frame_count=1.
REQ-029 SHIFT=3, acc0=0x1000, frame 0x1800 -> o_param0=0x1100; acc0=0x1000, frame 0x1003 -> 0x1001; acc0=0x0008, frame 0x0000 -> 0x0007; repeated frames converge exactly.
REQ-030 Second event during FILT1 -> two o_update pulses, o_overrun=0; third event while pending -> o_overrun=1, only two updates.
REQ-031 TIMEOUT=100, no frames -> o_stale=1 from cycle ~101; next event -> o_stale=0, counter restarts.
REQ-032 Assert i_reset during FILT2 -> all outputs 0, no o_update; next frame 0x0ABC -> o_param0=0x0ABC unfiltered.
REQ-033 256 frames -> o_frame_count wraps to 0, each frame one o_update.
